// File: rtl/mod_exp_unit.sv
// Multi-cycle modular exponentiation engine: result = base^exponent mod modulus.
// Right-to-left square-and-multiply, one exponent bit per cycle, fixed latency.
module mod_exp_unit #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 error
);

  localparam int CNT_W = $clog2(EXP_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 error_q, error_d;
  logic [WIDTH-1:0]     acc_step_s;

  // Double-width product reduced by the modulus; the remainder always fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(prod % {{WIDTH{1'b0}}, m});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      e_q      <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      e_q      <= e_d;
      mod_q    <= mod_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    b_d        = b_q;
    e_d        = e_q;
    mod_d      = mod_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    error_d    = error_q;
    acc_step_s = acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          b_d      = base;
          e_d      = exponent;
          mod_d    = modulus;
          acc_d    = '0;
          cnt_d    = '0;
          result_d = '0;
          error_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // A zero modulus has no meaningful remainder; report it and skip the loop.
        if (mod_q == '0) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          b_d     = b_q % mod_q;
          acc_d   = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
          cnt_d   = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (e_q[0]) begin
          acc_step_s = mul_mod(acc_q, b_q, mod_q);
        end else begin
          acc_step_s = acc_q;
        end
        acc_d = acc_step_s;
        b_d   = mul_mod(b_q, b_q, mod_q);
        e_d   = e_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // No early exit on a zero exponent so latency never depends on the data.
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step_s;
          state_d  = S_DONE;
        end else begin
          state_d = S_STEP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q == S_LOAD) || (state_q == S_STEP);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_mod_exp_unit.sv
// Self-checking bench for mod_exp_unit: directed spec cases plus randomized
// operands compared against a left-to-right exponentiation model.
module tb_mod_exp_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, busy, done, error;
  logic [31:0] base, exponent, modulus, result;

  logic        start64, busy64, done64, error64;
  logic [63:0] base64, exp64, mod64, result64;

  int n_cmp = 0;
  int n_bad = 0;

  mod_exp_unit dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .result(result), .error(error)
  );

  mod_exp_unit #(.WIDTH(64), .EXP_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .base(base64), .exponent(exp64),
    .modulus(mod64), .busy(busy64), .done(done64), .result(result64), .error(error64)
  );

  // Reference: left-to-right binary exponentiation with wide plain arithmetic.
  function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] e,
                                             input logic [63:0] m, input int ew);
    logic [127:0] r, bb, mm;
    if (m == 64'd0) return 64'd0;
    mm = {64'd0, m};
    bb = {64'd0, b} % mm;
    r  = 128'd1 % mm;
    for (int i = ew - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[63:0];
  endfunction

  task automatic start_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges from just after the accepting edge until done (lat = -1 on timeout).
  task automatic wait_done(output int lat, output int busy_cyc);
    lat = 0; busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start64 = 1'b0;
    base = '0; exponent = '0; modulus = '0;
    base64 = '0; exp64 = '0; mod64 = '0;
    #12;
    n_cmp++;
    if ({busy, done, error, result} !== 35'd0) begin
      n_bad++; $display("FAIL reset32: got busy=%b done=%b err=%b res=%0d expected all 0", busy, done, error, result);
    end
    n_cmp++;
    if ({busy64, done64, error64, result64} !== 67'd0) begin
      n_bad++; $display("FAIL reset64: got busy=%b done=%b err=%b res=%0d expected all 0", busy64, done64, error64, result64);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small;
    int lat, bc;
    start_op(32'd3, 32'd5, 32'd7);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL small_latency: got %0d expected 34", lat); end
    n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL small_busy: got %0d expected 33", bc); end
    n_cmp++; if (result !== 32'd5) begin n_bad++; $display("FAIL small_result: got %0d expected 5", result); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL small_error: got %b expected 0", error); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || result !== 32'd5) begin
      n_bad++; $display("FAIL small_hold: got done=%b res=%0d expected done=0 res=5", done, result);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, gap;
    start_op(32'd4, 32'd13, 32'd497);
    wait_done(lat, bc);
    n_cmp++; if (result !== 32'd445) begin n_bad++; $display("FAIL classic_result: got %0d expected 445", result); end
    base = 32'd2; exponent = 32'd10; modulus = 32'd1000; start = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, bc);
    n_cmp++; if (lat !== 34) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    n_cmp++; if (result !== 32'd24) begin n_bad++; $display("FAIL b2b_result: got %0d expected 24", result); end
    // Continuous start: period between done pulses is EXP_WIDTH+3.
    @(negedge clk);
    base = 32'd3; exponent = 32'd5; modulus = 32'd7; start = 1'b1;
    wait_done(lat, bc);
    gap = -1;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      if (done) begin gap = i; break; end
    end
    start = 1'b0;
    n_cmp++; if (gap !== 35) begin n_bad++; $display("FAIL b2b_period: got %0d expected 35", gap); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_boundaries;
    logic [31:0] ops [4][4];
    int lat, bc;
    ops = '{'{32'd10, 32'd3, 32'd7, 32'd6}, '{32'd9, 32'd0, 32'd5, 32'd1},
            '{32'd123, 32'd77, 32'd1, 32'd0}, '{32'd0, 32'd4, 32'd11, 32'd0}};
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i][0], ops[i][1], ops[i][2]);
      wait_done(lat, bc);
      n_cmp++;
      if (result !== ops[i][3] || error !== 1'b0 || lat !== 34) begin
        n_bad++; $display("FAIL boundary%0d: got res=%0d err=%b lat=%0d expected res=%0d err=0 lat=34",
                          i, result, error, lat, ops[i][3]);
      end
    end
  endtask

  task automatic test_zero_mod;
    int lat, bc;
    start_op(32'd5, 32'd3, 32'd0);
    wait_done(lat, bc);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL zmod_latency: got %0d expected 2", lat); end
    n_cmp++; if (error !== 1'b1 || result !== 32'd0) begin
      n_bad++; $display("FAIL zmod_flags: got err=%b res=%0d expected err=1 res=0", error, result);
    end
    start_op(32'd3, 32'd5, 32'd7);
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL zmod_clear: got err=%b expected 0", error); end
    wait_done(lat, bc);
    n_cmp++; if (error !== 1'b0 || result !== 32'd5) begin
      n_bad++; $display("FAIL zmod_next: got err=%b res=%0d expected err=0 res=5", error, result);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, bc, extra;
    start_op(32'd3, 32'd5, 32'd7);
    repeat (3) @(negedge clk);
    base = 32'd100; exponent = 32'd1; modulus = 32'd13; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(lat, bc);
    n_cmp++; if (lat + 4 !== 34) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 34", lat + 4); end
    n_cmp++; if (result !== 32'd5) begin n_bad++; $display("FAIL ignore_result: got %0d expected 5", result); end
    extra = 0;
    repeat (6) begin @(negedge clk); if (busy) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL ignore_queue: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    start_op(32'd4, 32'd13, 32'd497);
    repeat (11) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got busy=%b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, error, result} !== 35'd0) begin
      n_bad++; $display("FAIL midrst_outputs: got busy=%b done=%b err=%b res=%0d expected all 0", busy, done, error, result);
    end
    @(negedge clk); rst = 1'b0;
    start_op(32'd10, 32'd3, 32'd7);
    wait_done(lat, bc);
    n_cmp++; if (result !== 32'd6 || lat !== 34) begin
      n_bad++; $display("FAIL midrst_after: got res=%0d lat=%0d expected res=6 lat=34", result, lat);
    end
  endtask

  task automatic test_random;
    int lat, bc;
    logic [31:0] b, e, m;
    logic [63:0] exp_r;
    for (int i = 0; i < 8; i++) begin
      b = $urandom;
      e = $urandom;
      m = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
      exp_r = ref_modexp({32'd0, b}, {32'd0, e}, {32'd0, m}, 32);
      start_op(b, e, m);
      wait_done(lat, bc);
      n_cmp++;
      if (result !== exp_r[31:0] || error !== (m == 32'd0) || lat !== 34) begin
        n_bad++; $display("FAIL random%0d: b=%0d e=%0d m=%0d got res=%0d lat=%0d expected res=%0d lat=34",
                          i, b, e, m, result, lat, exp_r[31:0]);
      end
    end
  endtask

  task automatic test_width64;
    logic [63:0] b [2], e [2], m [2];
    logic [63:0] exp_r;
    int lat;
    b[0] = 64'h8000_0000_0000_0005; e[0] = '1; m[0] = 64'h1FFF_FFFF_FFFF_FFFF;
    b[1] = {$urandom, $urandom}; e[1] = {$urandom, $urandom}; m[1] = {$urandom, $urandom} | 64'd1;
    for (int k = 0; k < 2; k++) begin
      exp_r = ref_modexp(b[k], e[k], m[k], 64);
      @(negedge clk);
      base64 = b[k]; exp64 = e[k]; mod64 = m[k]; start64 = 1'b1;
      @(posedge clk); #1 start64 = 1'b0;
      lat = -1;
      for (int i = 1; i < 200; i++) begin
        @(negedge clk);
        if (done64) begin lat = i; break; end
      end
      n_cmp++;
      if (lat !== 66 || result64 !== exp_r || error64 !== 1'b0) begin
        n_bad++; $display("FAIL width64_%0d: got res=%h lat=%0d err=%b expected res=%h lat=66 err=0",
                          k, result64, lat, error64, exp_r);
      end
    end
  endtask

  initial begin
    test_reset;
    test_small;
    test_back_to_back;
    test_boundaries;
    test_zero_mod;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    test_width64;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_exp_unit.md
# mod_exp_unit

Multi-cycle modular exponentiation engine computing result = base^exponent mod modulus, with base, exponent and modulus parametrised in width. It replaces the fixed-exponent, fully combinational decrypt path of the single-cycle ALU. The unit sits beside the ALU and is driven by a start/done handshake from the execute stage, which stalls on busy.

## Interface
- WIDTH, 32: width of base, modulus and result.
- EXP_WIDTH, 32: width of exponent; sets the fixed number of step cycles.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- base  in  WIDTH  operand, latched at start.
- exponent  in  EXP_WIDTH  operand, latched at start.
- modulus  in  WIDTH  operand, latched at start.
- busy  out  1  high in LOAD and STEP.
- done  out  1  one-cycle pulse in DONE.
- result  out  WIDTH  final value; held from DONE until the next accepted start.
- error  out  1  modulus == 0 for the last operation; valid with done; held like result.

## Operation
- FSM states are IDLE, LOAD, STEP, DONE.
- IDLE -> LOAD on start. Latch base, exponent and modulus into internal registers. Clear result and error.
- LOAD, modulus == 0: set error=1 and result=0, then go to DONE (skip STEP).
- LOAD, otherwise:
  - b_reg = base % modulus.
  - acc = 1 % modulus (0 when modulus == 1).
  - e_reg = exponent.
  - cnt = 0.
  - Go to STEP.
- STEP performs one right-to-left square-and-multiply iteration per cycle:
  - if e_reg[0]: acc = (acc * b_reg) % modulus.
  - b_reg = (b_reg * b_reg) % modulus.
  - e_reg = e_reg >> 1.
  - cnt++.
  - When cnt == EXP_WIDTH-1: leave STEP after this cycle, with result = final acc.
- STEP always runs exactly EXP_WIDTH cycles. No early exit on e_reg == 0, so latency is data-independent.
- DONE: done=1 for one cycle, then return to IDLE unconditionally.
- Arithmetic width rules:
  - Products are 2*WIDTH bits and are reduced by an unsigned 2*WIDTH-bit modulo.
  - Reduced values are < modulus, so they fit in WIDTH bits with no truncation.
  - All operands are unsigned.
- Internal registers are the only state. The result written at DONE equals acc.

## Timing
- Reset values: state=IDLE; busy=0, done=0, result=0, error=0; internal registers 0.
- Reset asserted mid-operation: FSM returns to IDLE immediately and asynchronously. All outputs go to 0 and the partial result is discarded.
- Normal latency, with start sampled high at edge T:
  - LOAD at T+1.
  - STEP at T+2 .. T+EXP_WIDTH+1.
  - DONE at T+EXP_WIDTH+2, with done=1 and result valid.
  - Default configuration: 34 cycles.
- Zero-modulus latency: LOAD at T+1, DONE at T+2 with error=1.
- busy is high exactly in LOAD and STEP.
- start while busy, or in DONE, is ignored and not queued. Earliest next accept is the IDLE cycle after DONE.
- Back-to-back operation: start held high continuously gives one operation every EXP_WIDTH+3 cycles.
- Operand inputs may change freely after the start edge without affecting the running operation.
- exponent == 0: result = 1 % modulus.
- base == 0 with exponent != 0: result = 0.
- base >= modulus is legal; it is reduced in LOAD.

## Test plan
- Small case, defaults: base=3, exp=5, mod=7 -> done at start+34, result=5, error=0, busy high for 33 cycles.
- Classic case: base=4, exp=13, mod=497 -> result=445. Then base=2, exp=10, mod=1000 -> result=24, with a back-to-back start accepted in the IDLE cycle after done.
- Boundaries: base=10, exp=3, mod=7 -> 6; exp=0, base=9, mod=5 -> 1; mod=1 -> 0; base=0, exp=4, mod=11 -> 0.
- Zero modulus: mod=0 -> done at start+2, error=1, result=0; the next valid operation clears error.
- Robustness:
  - Pulse start and change operands during busy -> no effect on the running result, no second operation.
  - Assert rst at STEP cycle 10 -> outputs 0 and IDLE within the same cycle; a fresh start still completes correctly.
- Width sweep: WIDTH=64, EXP_WIDTH=64 with base=2^63+5, exp=2^64-1, mod=2^61-1 -> result matches the reference model, latency 66 cycles.
